// File: rtl/s_ram_reader_if.sv
// Read port plus output stream of the s_RAM reader.
// The master side belongs to the reader; the slave side is the RAM/consumer.
interface s_ram_reader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_valid;
  logic              out_ready;

  modport master (output address, out_data, out_index, out_valid,
                  input  q, out_ready);
  modport slave  (input  address, out_data, out_index, out_valid,
                  output q, out_ready);
endinterface

// File: rtl/s_ram_reader.sv
// Sweeps s_RAM addresses 0..DEPTH-1 and streams each word out over valid/ready.
// Optional identity-pattern checker is enabled by defining S_RAM_READER_CHECK_EN.
module s_ram_reader #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  s_ram_reader_if.master    bus,
  output logic              busy,
  output logic              stop
`ifdef S_RAM_READER_CHECK_EN
  ,
  output logic              mismatch,
  output logic [ADDR_W:0]   error_count,
  output logic [ADDR_W-1:0] first_error_addr
`endif
);

  localparam int CNT_W = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      bus.address   <= '0;
      bus.out_data  <= '0;
      bus.out_index <= '0;
      bus.out_valid <= 1'b0;
      busy          <= 1'b0;
      stop          <= 1'b0;
`ifdef S_RAM_READER_CHECK_EN
      mismatch         <= 1'b0;
      error_count      <= '0;
      first_error_addr <= '0;
`endif
    end else begin
      stop <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= ISSUE;
            bus.address <= '0;
            busy        <= 1'b1;
`ifdef S_RAM_READER_CHECK_EN
            mismatch         <= 1'b0;
            error_count      <= '0;
            first_error_addr <= '0;
`endif
          end
        end
        ISSUE: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end
        WAIT: begin
          if (wait_cnt == CNT_W'(RD_LATENCY - 1)) begin
            state         <= PRESENT;
            bus.out_data  <= bus.q;
            bus.out_index <= bus.address;
            bus.out_valid <= 1'b1;
`ifdef S_RAM_READER_CHECK_EN
            // Expected contents are the identity pattern s[i] = i.
            if (bus.q != DATA_W'(bus.address)) begin
              mismatch <= 1'b1;
              if (error_count != '1) error_count <= error_count + 1'b1;
              if (!mismatch) first_error_addr <= bus.address;
            end
`endif
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        PRESENT: begin
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            // Last address goes to DONE first, so the counter never wraps.
            if (&bus.address) begin
              state <= DONE;
              stop  <= 1'b1;
            end else begin
              bus.address <= bus.address + 1'b1;
              state       <= ISSUE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          busy          <= 1'b0;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s_ram_reader.sv
// Directed bench for s_ram_reader: latency-1 and latency-3 instances driven by RAM models.
// Checker outputs are exercised when S_RAM_READER_CHECK_EN is defined.
module tb_s_ram_reader;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start1 = 1'b0;
  logic start3 = 1'b0;
  logic rdy = 1'b1;
  logic busy1, stop1, busy3, stop3;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  s_ram_reader_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();
  s_ram_reader_if #(.ADDR_W(8), .DATA_W(8)) bus3 ();

`ifdef S_RAM_READER_CHECK_EN
  logic       mm1, mm3;
  logic [8:0] ec1, ec3;
  logic [7:0] fe1, fe3;
`endif

  s_ram_reader #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .bus(bus1.master),
    .busy(busy1), .stop(stop1)
`ifdef S_RAM_READER_CHECK_EN
    , .mismatch(mm1), .error_count(ec1), .first_error_addr(fe1)
`endif
  );

  s_ram_reader #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(3)) dut3 (
    .clock(clock), .reset(reset), .start(start3), .bus(bus3.master),
    .busy(busy3), .stop(stop3)
`ifdef S_RAM_READER_CHECK_EN
    , .mismatch(mm3), .error_count(ec3), .first_error_addr(fe3)
`endif
  );

  // RAM models: q is valid RD_LATENCY clocks after the address is sampled.
  logic [7:0] mem [256];
  logic [7:0] p1;
  logic [7:0] p3 [3];
  always @(posedge clock) p1 <= mem[bus1.address];
  always @(posedge clock) begin
    p3[0] <= mem[bus3.address];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign bus1.q         = p1;
  assign bus3.q         = p3[2];
  assign bus1.out_ready = rdy;
  assign bus3.out_ready = rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One sweep; optional stall, ignored start pulse and mid-sweep reset at given indices.
  task automatic sweep(input bit d3, input int stall_at, input int poke_at, input int rst_at);
    int n = 0, nb = 0, prev = -1, first_n = -1, stops = 0, stop_n = -1;
    int bad = 0, gap_bad = 0, stl = 0, stl_gap = 0, lat;
    bit held_bad = 1'b0, poked = 1'b0, done = 1'b0;
    logic v, s, b;
    logic [7:0] idx, dat, adr;
    lat = d3 ? 3 : 1;
    @(negedge clock);
    if (d3) start3 = 1'b1; else start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    start3 = 1'b0;
`ifdef S_RAM_READER_CHECK_EN
    if (!d3) begin
      chk("start_clr_mismatch", 32'(mm1), 0);
      chk("start_clr_count", 32'(ec1), 0);
      chk("start_clr_first", 32'(fe1), 0);
    end
`endif
    while (!done) begin
      v   = d3 ? bus3.out_valid : bus1.out_valid;
      idx = d3 ? bus3.out_index : bus1.out_index;
      dat = d3 ? bus3.out_data  : bus1.out_data;
      adr = d3 ? bus3.address   : bus1.address;
      s   = d3 ? stop3 : stop1;
      b   = d3 ? busy3 : busy1;
      start1 = 1'b0;
      rdy    = 1'b1;
      if (s) begin
        stops++;
        if (stop_n < 0) stop_n = n;
      end
      if (v && first_n < 0) first_n = n;
      if (stop_n >= 0 && n == stop_n + 1) begin
        chk("busy_after_stop", 32'(b), 0);
        done = 1'b1;
      end else if (v && rst_at >= 0 && 32'(idx) == rst_at) begin
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_valid", 32'(bus1.out_valid), 0);
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_stop", 32'(stop1), 0);
        chk("rst_no_stop_seen", 32'(stops), 0);
        chk("rst_beats", 32'(nb), 32'(rst_at));
        return;
      end else if (n >= 3000) begin
        chk("sweep_timeout", 32'(n), 0);
        done = 1'b1;
      end else begin
        if (v && poke_at >= 0 && 32'(idx) == poke_at && !poked) begin
          start1 = 1'b1;
          poked  = 1'b1;
        end
        if (v && stall_at >= 0 && 32'(idx) == stall_at && stl < 5) begin
          rdy = 1'b0;
          stl++;
          stl_gap++;
          if (32'(dat) != stall_at || 32'(adr) != stall_at) held_bad = 1'b1;
        end else if (v) begin
          if (32'(idx) != nb || dat != mem[idx]) bad++;
          if (prev >= 0 && n - prev != lat + 2 + stl_gap) gap_bad++;
          prev    = n;
          stl_gap = 0;
          nb++;
        end
        @(negedge clock);
        n++;
      end
    end
    rdy = 1'b1;
    chk("beats", 32'(nb), 256);
    chk("data_order", 32'(bad), 0);
    chk("beat_spacing", 32'(gap_bad), 0);
    chk("first_valid", 32'(first_n), 32'(lat + 1));
    chk("stop_pulses", 32'(stops), 1);
    chk("stop_cycle", 32'(stop_n), 32'(256 * (lat + 2) + stl));
    if (stall_at >= 0) begin
      chk("stall_held", 32'(held_bad), 0);
      chk("stall_cycles", 32'(stl), 5);
    end
  endtask

  initial begin
    int vseen;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_address", 32'(bus1.address), 0);
    chk("rst_out_data", 32'(bus1.out_data), 0);
    chk("rst_out_index", 32'(bus1.out_index), 0);
    chk("rst_out_valid", 32'(bus1.out_valid), 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_stop", 32'(stop1), 0);
    vseen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus1.out_valid || busy1 || stop1) vseen++;
    end
    chk("idle_quiet", 32'(vseen), 0);

    sweep(1'b0, -1, -1, -1);   // full sweep, latency 1
    sweep(1'b0, 17, -1, -1);   // consumer stall at index 17
    sweep(1'b0, -1, 50, 100);  // ignored start, then reset mid-sweep
    sweep(1'b0, -1, -1, -1);   // fresh start restarts from index 0
    sweep(1'b1, -1, -1, -1);   // latency 3

`ifdef S_RAM_READER_CHECK_EN
    mem[42]  = 8'd0;
    mem[200] = 8'd7;
    sweep(1'b0, -1, -1, -1);
    chk("mismatch_flag", 32'(mm1), 1);
    chk("error_count", 32'(ec1), 2);
    chk("first_error_addr", 32'(fe1), 42);
    mem[42]  = 8'd42;
    mem[200] = 8'd200;
    sweep(1'b0, -1, -1, -1);
    chk("clean_mismatch", 32'(mm1), 0);
    chk("clean_count", 32'(ec1), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/s_ram_reader.md
Name: s_ram_reader

Overview:
- Read-side counterpart to the s_RAM initializer: sweeps s_RAM addresses 0..DEPTH-1 and streams each byte out over a valid/ready interface.
- Used to dump and verify s_RAM contents after initialization or key scheduling, and to feed downstream consumers such as a display/debug port or checker.
- Never writes s_RAM; the top-level mux gives it the s_RAM address port only while `busy` is high.

Parameters:
- ADDR_W, 8: s_RAM address width; DEPTH = 2**ADDR_W.
- DATA_W, 8: s_RAM word width.
- RD_LATENCY, 1: clocks from the address being sampled by the RAM to `q` being valid; legal range 1..4.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- address  out  ADDR_W  s_RAM read address (registered).
- q  in  DATA_W  s_RAM read data.
- out_data  out  DATA_W  captured word.
- out_index  out  ADDR_W  address that `out_data` came from.
- out_valid  out  1  `out_data`/`out_index` valid.
- out_ready  in  1  consumer accepts the beat.
- busy  out  1  high from leaving IDLE until DONE completes.
- stop  out  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - state = IDLE.
  - address, out_data, out_index, out_valid, busy and stop all = 0.
  - Internal address register = 0 and wait counter = 0.
  - Applies identically mid-sweep; there is no partial-completion `stop` pulse.
- IDLE: start=1 -> ISSUE, with address = 0.
- ISSUE: one cycle with `address` stable -> WAIT, with wait counter = 0.
- WAIT: lasts exactly RD_LATENCY cycles.
  - On the final WAIT edge: capture `q` into out_data, address into out_index, set out_valid=1 -> PRESENT.
- PRESENT: out_valid=1; out_data and out_index held stable while out_ready=0.
  - On the out_valid & out_ready edge, clear out_valid, then:
    - address == DEPTH-1 -> DONE.
    - otherwise address = address+1 -> ISSUE.
- DONE: stop=1 for exactly one cycle -> IDLE.
  - `address` keeps DEPTH-1 until the next start.
- `busy` = (state != IDLE).
- `start` is ignored in every state other than IDLE.
  - start held high through DONE does not restart until IDLE is reached: the earliest new ISSUE is 2 cycles after the stop cycle.
- Address increment is ADDR_W-wide. Wrap from DEPTH-1 never occurs because DONE is taken first.
- Throughput with out_ready tied high: RD_LATENCY+2 cycles per beat.
  - The first beat's out_valid rises RD_LATENCY+1 cycles after the start-sampling edge.
  - At defaults the full sweep is 768 cycles from that edge to the stop cycle.
- Undefined state encodings go to IDLE on the next clock.

Optional Feature:
- Macro: S_RAM_READER_CHECK_EN.
- When defined, add these outputs:
  - `mismatch` (1 bit): sticky; cleared on reset and on each accepted start.
  - `error_count` (ADDR_W+1 bits).
  - `first_error_addr` (ADDR_W bits).
- Check rule: at each capture, compare q against the ADDR_W-bit address zero-extended/truncated to DATA_W, i.e. the identity pattern s[i]=i.
- On a mismatch:
  - error_count increments, saturating at all-ones.
  - first_error_addr is loaded only on the first mismatch of the sweep.
  - mismatch is set.
- When not defined: these ports do not exist, and streaming behaviour is identical.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0; out_valid never rises with start=0.
- Identity RAM model, RD_LATENCY=1, out_ready=1, start pulse -> 256 beats, out_index 0..255 in order, out_data==out_index, single stop pulse 768 cycles after the start-sampling edge, busy low the cycle after the stop cycle.
- Drop out_ready for 5 cycles while out_index=17 -> out_valid stays 1 and out_data=17 holds; address does not advance; index 18 follows normally; no beat lost or duplicated.
- Pulse start again at out_index=50, then assert reset at out_index=100 -> second start has no effect; reset gives out_valid=0 and busy=0 on the following cycle with no stop; a fresh start restarts from index 0.
- Rerun with RD_LATENCY=3 and a latency-accurate RAM model -> each beat is 5 cycles apart and all data is correct.
- S_RAM_READER_CHECK_EN with s[42]=0 and s[200]=7 -> mismatch=1, error_count=2, first_error_addr=42 at stop; next start clears all three.
